// File: rtl/aer_pkg.sv
// Shared definitions for the AER input event buffer.
// Contents: event-type codes carried in the top two bits of an AER word,
// the default event word type, and the state enums of the input and
// output handshake FSMs.
package aer_pkg;

  localparam int AER_WIDTH_DEF = 12;

  localparam logic [1:0] EVT_NEUR    = 2'b00;
  localparam logic [1:0] EVT_BCAST   = 2'b01;
  localparam logic [1:0] EVT_INVALID = 2'b11;

  typedef logic [AER_WIDTH_DEF-1:0] aer_evt_t;

  typedef enum logic {
    I_IDLE,
    I_ACK
  } in_state_t;

  typedef enum logic [1:0] {
    O_IDLE,
    O_REQ,
    O_REL
  } out_state_t;

endpackage

// File: rtl/aer_in_event_buffer_if.sv
// 4-phase REQ/ACK event link.
// Signals: req (request), ack (acknowledge), data (event word, stable while req is high).
// Modports: master drives req/data and samples ack; slave does the reverse.
interface aer_in_event_buffer_if #(
  parameter int WIDTH = 12
);
  logic             req;
  logic             ack;
  logic [WIDTH-1:0] data;

  modport master (output req, output data, input ack);
  modport slave  (input req, input data, output ack);
endinterface

// File: rtl/aer_sync_fifo.sv
// Synchronous show-ahead FIFO used to buffer AER events.
// Ports: clk/rst_n (async active-low reset), push/din (write), pop (read),
//        dout (current head), full, empty, level (occupancy).
// A push while full is accepted only if the same cycle pops.
module aer_sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry an extra MSB lap flag so full and empty are distinguishable.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign level   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Read and write pointer advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/aer_in_event_buffer.sv
// Upstream stage of the LRF mapper: accepts off-chip AER events on an
// asynchronous 4-phase link, drops invalid (type 2'b11) events, buffers the
// rest and replays them one at a time on a synchronous 4-phase mapper link.
// Ports: clk, rst_n (async active-low), aerin (slave link from off-chip),
//        map_in (master link to mapper), MAP_IN_AERIN_IDX (event payload),
//        FIFO_LEVEL (occupancy), DROP_CNT (saturating invalid-event count).
module aer_in_event_buffer
  import aer_pkg::*;
#(
  parameter int AER_WIDTH   = 12,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  aer_in_event_buffer_if.slave          aerin,
  aer_in_event_buffer_if.master         map_in,
  output logic [AER_WIDTH-3:0]          MAP_IN_AERIN_IDX,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic [15:0]                   DROP_CNT
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;

  in_state_t              in_state, in_state_d;
  logic                   ack_q, ack_d;
  logic                   push, drop, evt_invalid;

  out_state_t             out_state, out_state_d;
  logic                   req_q, req_d, pop;
  logic [AER_WIDTH-1:0]   evt_q, evt_d;

  logic [AER_WIDTH-1:0]   fifo_dout;
  logic                   fifo_full, fifo_empty;

  assign req_s       = sync_q[SYNC_STAGES-1];
  assign evt_invalid = (aerin.data[AER_WIDTH-1 -: 2] == EVT_INVALID);

  aer_sync_fifo #(.WIDTH(AER_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (aerin.data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (FIFO_LEVEL)
  );

  // Metastability synchroniser on the asynchronous off-chip request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], aerin.req};
  end

  // Input FSM state and registered off-chip acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state <= I_IDLE;
      ack_q    <= 1'b0;
    end else begin
      in_state <= in_state_d;
      ack_q    <= ack_d;
    end
  end

  // Input FSM: invalid events are acknowledged without a FIFO slot, so they
  // never stall; valid events wait for space (or a same-cycle pop).
  always_comb begin
    in_state_d = in_state;
    ack_d      = ack_q;
    push       = 1'b0;
    drop       = 1'b0;
    case (in_state)
      I_IDLE: begin
        if (req_s) begin
          if (evt_invalid) begin
            drop       = 1'b1;
            ack_d      = 1'b1;
            in_state_d = I_ACK;
          end else if (!fifo_full || pop) begin
            push       = 1'b1;
            ack_d      = 1'b1;
            in_state_d = I_ACK;
          end
        end
      end
      I_ACK: begin
        if (!req_s) begin
          ack_d      = 1'b0;
          in_state_d = I_IDLE;
        end
      end
      default: in_state_d = I_IDLE;
    endcase
  end

  // Saturating counter of discarded invalid events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            DROP_CNT <= '0;
    else if (drop && DROP_CNT != 16'hFFFF) DROP_CNT <= DROP_CNT + 16'd1;
  end

  // Output FSM state plus registered mapper request and event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_state <= O_IDLE;
      req_q     <= 1'b0;
      evt_q     <= '0;
    end else begin
      out_state <= out_state_d;
      req_q     <= req_d;
      evt_q     <= evt_d;
    end
  end

  // Output FSM: the head stays in the FIFO until the mapper acknowledges it;
  // on release the next head may be presented in the same cycle.
  always_comb begin
    out_state_d = out_state;
    req_d       = req_q;
    evt_d       = evt_q;
    pop         = 1'b0;
    case (out_state)
      O_IDLE: begin
        if (!fifo_empty) begin
          req_d       = 1'b1;
          evt_d       = fifo_dout;
          out_state_d = O_REQ;
        end
      end
      O_REQ: begin
        if (map_in.ack) begin
          req_d       = 1'b0;
          pop         = 1'b1;
          out_state_d = O_REL;
        end
      end
      O_REL: begin
        if (!map_in.ack) begin
          if (!fifo_empty) begin
            req_d       = 1'b1;
            evt_d       = fifo_dout;
            out_state_d = O_REQ;
          end else begin
            out_state_d = O_IDLE;
          end
        end
      end
      default: out_state_d = O_IDLE;
    endcase
  end

  assign aerin.ack        = ack_q;
  assign map_in.req       = req_q;
  assign map_in.data      = evt_q;
  assign MAP_IN_AERIN_IDX = evt_q[AER_WIDTH-3:0];
endmodule

// File: tb/tb_aer_in_event_buffer.sv
// Testbench for aer_in_event_buffer: directed off-chip events, a mapper
// responder, and a scoreboard queue of expected events checked on every
// rising mapper request.
module tb_aer_in_event_buffer;
  import aer_pkg::*;

  localparam int W  = 12;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-3:0]  idx;
  logic [LW-1:0] level;
  logic [15:0]   drop_cnt;

  aer_in_event_buffer_if #(.WIDTH(W)) aerin_if ();
  aer_in_event_buffer_if #(.WIDTH(W)) map_if ();

  aer_in_event_buffer #(.AER_WIDTH(W), .FIFO_DEPTH(16), .SYNC_STAGES(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .aerin            (aerin_if),
    .map_in           (map_if),
    .MAP_IN_AERIN_IDX (idx),
    .FIFO_LEVEL       (level),
    .DROP_CNT         (drop_cnt)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           failures = 0;
  int           exp_drop = 0;
  logic [W-1:0] sb_q[$];
  bit           map_auto = 1'b0;
  bit           prev_req = 1'b0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=timeout expected=handshake", name);
  endtask

  // Full off-chip 4-phase handshake; called at posedge+2, returns at posedge+2.
  task automatic applyStimulus(input logic [W-1:0] addr, output int lat);
    int n;
    lat = 0;
    aerin_if.data = addr;
    aerin_if.req  = 1'b1;
    if (addr[W-1 -: 2] == EVT_INVALID) exp_drop++;
    else                               sb_q.push_back(addr);
    while (!aerin_if.ack && lat < 100) begin
      @(posedge clk); lat++; #1;
    end
    if (!aerin_if.ack) reportTimeout("aerin_ack_rise");
    aerin_if.req = 1'b0;
    n = 0;
    while (aerin_if.ack && n < 100) begin
      @(posedge clk); n++; #1;
    end
    if (aerin_if.ack) reportTimeout("aerin_ack_fall");
    @(posedge clk); #2;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((sb_q.size() != 0 || map_if.req || map_if.ack) && n < 3000) begin
      @(posedge clk); n++;
    end
    #2;
    if (sb_q.size() != 0 || map_if.req) reportTimeout("drain");
  endtask

  task automatic waitMapReq();
    int n = 0;
    while (!map_if.req && n < 50) begin
      @(posedge clk); n++; #2;
    end
    if (!map_if.req) reportTimeout("map_req_rise");
  endtask

  // Monitor and mapper responder: compares each newly presented event with
  // the scoreboard head, and acknowledges automatically when enabled.
  initial begin
    logic [W-1:0] exp;
    map_if.ack = 1'b0;
    forever begin
      @(negedge clk);
      if (map_if.req && !prev_req) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_event actual=%0h expected=none", map_if.data);
        end else begin
          exp = sb_q.pop_front();
          checkOutput("map_event", map_if.data, exp);
          checkOutput("map_idx", idx, exp[W-3:0]);
        end
      end
      prev_req = map_if.req;
      if (map_auto) begin
        if (map_if.req && !map_if.ack)      map_if.ack = 1'b1;
        else if (!map_if.req && map_if.ack) map_if.ack = 1'b0;
      end
    end
  end

  initial begin
    int lat;
    int n;
    aerin_if.req  = 1'b0;
    aerin_if.data = '0;
    rst_n = 1'b0;
    waitCycles(3);
    rst_n = 1'b1;
    waitCycles(1);
    checkOutput("reset_aerin_ack", aerin_if.ack, 0);
    checkOutput("reset_map_req", map_if.req, 0);
    checkOutput("reset_level", level, 0);
    checkOutput("reset_drop_cnt", drop_cnt, 0);
    checkOutput("reset_map_event", map_if.data, 0);

    // Single neuron event, checking the off-chip ACK latency.
    map_auto = 1'b1;
    applyStimulus(12'h015, lat);
    checkOutput("ack_latency", lat, 3);
    waitDrain();
    checkOutput("level_after_single", level, 0);

    // Invalid event is acknowledged and counted but never forwarded.
    applyStimulus(12'hFFF, lat);
    waitCycles(6);
    checkOutput("drop_cnt_after_invalid", drop_cnt, exp_drop);
    checkOutput("map_req_after_invalid", map_if.req, 0);
    checkOutput("level_after_invalid", level, 0);

    // Backpressure: mapper stalled, 16 events fill the buffer, 17th is held.
    map_auto = 1'b0;
    for (int i = 0; i < 16; i++) applyStimulus(W'(i), lat);
    checkOutput("level_full", level, 16);
    aerin_if.data = 12'h010;
    aerin_if.req  = 1'b1;
    sb_q.push_back(12'h010);
    waitCycles(10);
    checkOutput("ack_held_when_full", aerin_if.ack, 0);
    checkOutput("level_still_full", level, 16);
    map_auto = 1'b1;
    n = 0;
    while (!aerin_if.ack && n < 100) begin
      @(posedge clk); n++; #2;
    end
    if (!aerin_if.ack) reportTimeout("ack_after_release");
    aerin_if.req = 1'b0;
    n = 0;
    while (aerin_if.ack && n < 100) begin
      @(posedge clk); n++; #2;
    end
    waitDrain();
    checkOutput("level_after_burst", level, 0);

    // Broadcast event passes unchanged.
    applyStimulus(12'h400, lat);
    waitDrain();

    // Same-cycle push and pop with one entry buffered.
    map_auto = 1'b0;
    applyStimulus(12'h0A1, lat);
    waitMapReq();
    aerin_if.data = 12'h0B2;
    aerin_if.req  = 1'b1;
    sb_q.push_back(12'h0B2);
    waitCycles(2);
    map_if.ack = 1'b1;
    waitCycles(1);
    checkOutput("level_push_pop", level, 1);
    checkOutput("aerin_ack_push_pop", aerin_if.ack, 1);
    checkOutput("map_req_dropped_push_pop", map_if.req, 0);
    map_if.ack = 1'b0;
    map_auto = 1'b1;
    aerin_if.req = 1'b0;
    waitCycles(4);
    checkOutput("aerin_ack_released", aerin_if.ack, 0);
    waitDrain();

    // Reset in the middle of both handshakes.
    map_auto = 1'b0;
    applyStimulus(12'h023, lat);
    waitMapReq();
    aerin_if.data = 12'h024;
    aerin_if.req  = 1'b1;
    sb_q.push_back(12'h024);
    n = 0;
    while (!aerin_if.ack && n < 100) begin
      @(posedge clk); n++; #2;
    end
    if (!aerin_if.ack) reportTimeout("ack_before_reset");
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_map_req", map_if.req, 0);
    checkOutput("async_reset_aerin_ack", aerin_if.ack, 0);
    sb_q.delete();
    exp_drop = 0;
    aerin_if.req = 1'b0;
    waitCycles(3);
    rst_n = 1'b1;
    waitCycles(3);
    checkOutput("level_after_reset", level, 0);
    checkOutput("drop_cnt_after_reset", drop_cnt, exp_drop);
    checkOutput("map_req_after_reset", map_if.req, 0);
    checkOutput("scoreboard_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
